// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10, one per rk_valid/rk_ready handshake.
// Define AES_KEY_STORE_EN to add an 11-entry round-key store with a combinational read port.
module aes_key_expand #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter logic [7:0]  RCON_INIT  = 8'h01
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] round_key,
  output logic [3:0]   rk_idx,
  output logic         done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rd_addr,
  output logic [0:127] rd_key
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Handshake: a round key transfers on every rising edge where rk_valid && rk_ready;
  // while rk_valid is high and rk_ready is low, round_key and rk_idx hold.
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [0:127] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic         load, accept, advance, finish;
  logic [0:31]  w0, w1, w2, w3, rot, sub, t;
  logic [0:31]  n0, n1, n2, n3;
  logic [0:127] next_key;

  assign load    = (state_q == IDLE) && start;
  assign accept  = (state_q == EMIT) && rk_ready;
  assign advance = accept && (idx_q != LAST_IDX);
  assign finish  = accept && (idx_q == LAST_IDX);

  // Whole next round key in one combinational pass from the current one.
  always_comb begin
    w0  = key_q[0:31];
    w1  = key_q[32:63];
    w2  = key_q[64:95];
    w3  = key_q[96:127];
    rot = {w3[8:31], w3[0:7]};
    sub = {sbox(rot[0:7]), sbox(rot[8:15]), sbox(rot[16:23]), sbox(rot[24:31])};
    t   = sub ^ {rcon_q, 24'h000000};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          rcon_d  = RCON_INIT;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (advance) begin
          key_d  = next_key;
          idx_d  = idx_q + 4'd1;
          rcon_d = xtime(rcon_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= RCON_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == EMIT);
  assign rk_valid  = (state_q == EMIT);
  assign round_key = key_q;
  assign rk_idx    = idx_q;
  assign done      = done_q;

`ifdef AES_KEY_STORE_EN
  // Each key is written as soon as it exists, so the table is complete once done fires.
  logic [0:127] store_q [11];
  logic [0:127] store_d [11];

  always_comb begin
    store_d = store_q;
    if (load) begin
      store_d[0] = key_in;
    end else if (advance) begin
      store_d[idx_q + 4'd1] = next_key;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      store_q <= '{default: '0};
    end else begin
      store_q <= store_d;
    end
  end

  assign rd_key = (rd_addr <= LAST_IDX) ? store_q[rd_addr] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand; the reference builds the S-box from GF(2^8)
// inversion and expands keys with the textbook 44-word schedule.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:127] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [0:127] round_key;
  logic [3:0]   rk_idx;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_addr;
  logic [0:127] rd_key;
`endif

  aes_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .rk_idx    (rk_idx),
    .done      (done)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_addr   (rd_addr),
    .rd_key    (rd_key)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] model_rk [11];
  logic [127:0] obs_rk [11];

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_F = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  // reference model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] xv, inv, r1, r2, r3, r4;
    for (int x = 0; x < 256; x++) begin
      xv  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(xv, 8'(y)) == 8'h01) inv = 8'(y);
      end
      r1 = rotl1(inv);
      r2 = rotl1(r1);
      r3 = rotl1(r2);
      r4 = rotl1(r3);
      sbox_t[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_t[temp[31:24]], sbox_t[temp[23:16]], sbox_t[temp[15:8]], sbox_t[temp[7:0]]};
        temp = temp ^ {rc, 24'h000000};
        rc   = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = rand_key();
    step();
    step();
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b rk_valid=%b done=%b, required 0 0 0", busy, rk_valid, done);
    end
    checks++;
    if (rk_idx !== 4'd0 || round_key !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: rk_idx=%0d round_key=%h, required 0 and 0", rk_idx, round_key);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: rk_valid=%b busy=%b, required 0 0", rk_valid, busy);
    end
  endtask

  // Starts one expansion of key and follows it to done, checking every presented key.
  task automatic test_stream(input logic [127:0] key, input bit rand_ready);
    int   k;
    int   cyc;
    logic rdy;
    compute_model(key);
    key_in = key;
    start  = 1'b1;
    step();
    start  = 1'b0;
    key_in = rand_key();
    k   = 0;
    cyc = 0;
    while (k <= 10 && cyc < 400) begin
      checks++;
      if (rk_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          rk_idx !== 4'(k) || round_key !== model_rk[k]) begin
        errors++;
        $display("FAIL stream_key%0d: valid=%b busy=%b done=%b idx=%0d key=%h, required 1 1 0 %0d %h",
                 k, rk_valid, busy, done, rk_idx, round_key, k, model_rk[k]);
      end
      obs_rk[k] = round_key;
      rdy      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      start    = 1'($urandom_range(0, 1));
      step();
      cyc++;
      if (rdy) k++;
    end
    start = 1'b0;
    checks++;
    if (k <= 10) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d keys, required 11", k);
    end
    checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 ||
        rk_idx !== 4'd10 || round_key !== model_rk[10]) begin
      errors++;
      $display("FAIL stream_done: done=%b valid=%b busy=%b idx=%0d key=%h, required 1 0 0 10 %h",
               done, rk_valid, busy, rk_idx, round_key, model_rk[10]);
    end
    if (!rand_ready) begin
      checks++;
      if (cyc != 11) begin
        errors++;
        $display("FAIL stream_cycles: %0d valid cycles, required 11", cyc);
      end
    end
    rk_ready = 1'($urandom_range(0, 1));
    step();
    checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b valid=%b one cycle later, required 0 0", done, rk_valid);
    end
  endtask

  task automatic test_known_vectors();
    test_stream(KEY_A, 1'b0);
    checks++;
    if (obs_rk[0] !== KEY_A || obs_rk[1] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe ||
        obs_rk[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      errors++;
      $display("FAIL vector_a: k0=%h k1=%h k10=%h", obs_rk[0], obs_rk[1], obs_rk[10]);
    end
    test_stream(KEY_F, 1'b0);
    checks++;
    if (obs_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
        obs_rk[9] !== 128'hac7766f319fadc2128d12941575c006e ||
        obs_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL vector_fips: k1=%h k9=%h k10=%h", obs_rk[1], obs_rk[9], obs_rk[10]);
    end
  endtask

`ifdef AES_KEY_STORE_EN
  task automatic test_store();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      checks++;
      if (rd_key !== ((a <= 10) ? model_rk[a] : 128'h0)) begin
        errors++;
        $display("FAIL store_rd%0d: rd_key=%h, required %h", a, rd_key,
                 (a <= 10) ? model_rk[a] : 128'h0);
      end
    end
    rd_addr = 4'd0;
  endtask
`endif

  task automatic test_backpressure();
    test_stream(KEY_F, 1'b1);
    checks++;
    if (obs_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
        obs_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL backpressure_fips: k1=%h k10=%h", obs_rk[1], obs_rk[10]);
    end
    for (int n = 0; n < 4; n++) test_stream(rand_key(), 1'b1);
  endtask

  task automatic test_start_ignored();
    logic [127:0] key_a;
    logic [127:0] key_b;
    int           k;
    key_a = rand_key();
    key_b = rand_key();
    compute_model(key_a);
    key_in   = key_a;
    start    = 1'b1;
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    for (k = 0; k <= 10; k++) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(k) || round_key !== model_rk[k]) begin
        errors++;
        $display("FAIL restart_ignored_key%0d: valid=%b idx=%0d key=%h, required 1 %0d %h",
                 k, rk_valid, rk_idx, round_key, k, model_rk[k]);
      end
      start  = (k == 4);
      key_in = (k == 4) ? key_b : key_a;
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: done=%b, required 1", done);
    end
    start  = 1'b1;
    key_in = key_b;
    step();
    start = 1'b0;
    compute_model(key_b);
    for (k = 0; k <= 10; k++) begin
      checks++;
      if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_idx !== 4'(k) || round_key !== model_rk[k]) begin
        errors++;
        $display("FAIL start_in_done_key%0d: valid=%b busy=%b idx=%0d key=%h, required 1 1 %0d %h",
                 k, rk_valid, busy, rk_idx, round_key, k, model_rk[k]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done_done: done=%b, required 1", done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    compute_model(KEY_A);
    key_in   = KEY_A;
    start    = 1'b1;
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (rk_idx !== 4'(k) || round_key !== model_rk[k]) begin
        errors++;
        $display("FAIL pre_abort_key%0d: idx=%0d key=%h, required %0d %h",
                 k, rk_idx, round_key, k, model_rk[k]);
      end
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort: valid=%b busy=%b idx=%0d done=%b, required 0 0 0 0",
               rk_valid, busy, rk_idx, done);
    end
    step();
    checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done=%b valid=%b, required 0 0", done, rk_valid);
    end
    test_stream(KEY_A, 1'b0);
    checks++;
    if (obs_rk[0] !== KEY_A || obs_rk[1] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin
      errors++;
      $display("FAIL after_abort: k0=%h k1=%h", obs_rk[0], obs_rk[1]);
    end
  endtask

  initial begin
`ifdef AES_KEY_STORE_EN
    rd_addr = 4'd0;
`endif
    build_sbox();
    test_reset();
    test_known_vectors();
`ifdef AES_KEY_STORE_EN
    test_store();
`endif
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
